// File: rtl/result_trace.sv
// Result trace buffer: captures qualifying samples into a small circular store and
// presents the oldest entry on a first-word fall-through read port.
module result_trace #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 16,  // power of two, >= 2
  parameter int unsigned WRAP     = 0,   // 1: overwrite oldest entry when full
  parameter int unsigned CHG_ONLY = 0    // 1: capture only when sample changes
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [WIDTH-1:0]       sample,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             has_last_q, has_last_d;

  logic cap;
  logic rd;
  logic do_write;
  logic evict;  // full with WRAP: write replaces the oldest entry
  logic drop;   // full without WRAP: qualifying sample is lost

  // Outputs derive from registered state only; nothing here sees en or sample.
  always_comb begin
    rd_valid = (count_q != '0);
    rd_data  = mem_q[rd_ptr_q];
    count    = count_q;
    full     = (count_q == CntMax);
    overflow = overflow_q;
  end

  // Capture qualification, read handshake and next-state for pointers and flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    last_d     = last_q;
    has_last_d = has_last_q;
    do_write   = 1'b0;
    evict      = 1'b0;
    drop       = 1'b0;

    cap = en && ((CHG_ONLY == 0) || !has_last_q || (sample != last_q));
    rd  = rd_valid && rd_ready;

    if (cap) begin
      if (!full || rd) begin
        do_write = 1'b1;
      end else if (WRAP != 0) begin
        do_write = 1'b1;
        evict    = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end

    if (do_write) begin
      wr_ptr_d   = wr_ptr_q + PtrW'(1);
      last_d     = sample;
      has_last_d = 1'b1;
    end

    if (rd || evict) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    if (evict || drop) begin
      overflow_d = 1'b1;
    end

    // An eviction is a write paired with an implicit read, so count holds.
    if (do_write && !rd && !evict) begin
      count_d = count_q + CntW'(1);
    end else if (rd && !do_write) begin
      count_d = count_q - CntW'(1);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      last_q     <= '0;
      has_last_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      last_q     <= last_d;
      has_last_q <= has_last_d;
    end
  end

  // Entry storage; contents are not reset, count gates their visibility.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      mem_q[wr_ptr_q] <= sample;
    end
  end

endmodule

// File: tb/tb_result_trace.sv
// Bench for result_trace: four DEPTH=4 instances covering WRAP x CHG_ONLY share one stimulus
// stream and are compared against a queue-based model after every clock.
module tb_result_trace;

  localparam int NCFG = 4;
  localparam int D    = 4;

  logic        clk = 1'b0;
  logic        rst, en, rd_ready;
  logic [31:0] sample;

  logic        rd_valid_w [NCFG];
  logic [31:0] rd_data_w  [NCFG];
  logic [2:0]  count_w    [NCFG];
  logic        full_w     [NCFG];
  logic        overflow_w [NCFG];

  always #5 clk = ~clk;

  // cfg k: WRAP = k % 2, CHG_ONLY = k / 2
  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    result_trace #(
      .WIDTH   (32),
      .DEPTH   (D),
      .WRAP    (g % 2),
      .CHG_ONLY(g / 2)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .sample  (sample),
      .rd_ready(rd_ready),
      .rd_valid(rd_valid_w[g]),
      .rd_data (rd_data_w[g]),
      .count   (count_w[g]),
      .full    (full_w[g]),
      .overflow(overflow_w[g])
    );
  end

  int total = 0;
  int bad   = 0;

  // Reference model state per configuration
  logic [31:0] mq [NCFG][$];
  bit          m_ovf  [NCFG];
  bit          m_has  [NCFG];
  logic [31:0] m_last [NCFG];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int k, input bit r, input bit e, input logic [31:0] s,
                            input bit rr);
    bit wrap;
    bit chg;
    bit rd;
    bit cap;
    int n;
    wrap = (k % 2) == 1;
    chg  = (k / 2) == 1;
    if (r) begin
      mq[k].delete();
      m_ovf[k]  = 1'b0;
      m_has[k]  = 1'b0;
      m_last[k] = '0;
    end else begin
      n   = mq[k].size();
      rd  = (n != 0) && rr;
      cap = e && (!chg || !m_has[k] || (s != m_last[k]));
      if (rd) void'(mq[k].pop_front());
      if (cap) begin
        if (n < D || rd) begin
          mq[k].push_back(s);
          m_last[k] = s;
          m_has[k]  = 1'b1;
        end else if (wrap) begin
          void'(mq[k].pop_front());
          mq[k].push_back(s);
          m_last[k] = s;
          m_has[k]  = 1'b1;
          m_ovf[k]  = 1'b1;
        end else begin
          m_ovf[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_cfg(input int k);
    int n;
    n = mq[k].size();
    chk($sformatf("cfg%0d count", k), 32'(count_w[k]), 32'(n));
    chk($sformatf("cfg%0d rd_valid", k), 32'(rd_valid_w[k]), 32'(n != 0));
    chk($sformatf("cfg%0d full", k), 32'(full_w[k]), 32'(n == D));
    chk($sformatf("cfg%0d overflow", k), 32'(overflow_w[k]), 32'(m_ovf[k]));
    if (n != 0) chk($sformatf("cfg%0d rd_data", k), rd_data_w[k], mq[k][0]);
  endtask

  task automatic tick(input bit r, input bit e, input logic [31:0] s, input bit rr);
    rst      = r;
    en       = e;
    sample   = s;
    rd_ready = rr;
    for (int k = 0; k < NCFG; k++) model_step(k, r, e, s, rr);
    @(posedge clk);
    #1;
    for (int k = 0; k < NCFG; k++) check_cfg(k);
  endtask

  logic [31:0] exp_seq [4];

  initial begin
    // Reset state
    tick(1, 0, 0, 0);
    chk("reset count", 32'(count_w[0]), 0);
    chk("reset rd_valid", 32'(rd_valid_w[0]), 0);
    chk("reset full", 32'(full_w[0]), 0);
    chk("reset overflow", 32'(overflow_w[0]), 0);

    // Basic capture with fall-through read data
    tick(0, 1, 5, 0);
    chk("basic count1", 32'(count_w[0]), 1);
    chk("basic fwft", rd_data_w[0], 5);
    tick(0, 1, 6, 0);
    chk("basic count2", 32'(count_w[0]), 2);
    tick(0, 1, 7, 0);
    chk("basic count3", 32'(count_w[0]), 3);
    chk("basic head", rd_data_w[0], 5);
    chk("basic overflow", 32'(overflow_w[0]), 0);

    // Overfill: drop (WRAP=0) versus overwrite (WRAP=1)
    tick(1, 0, 0, 0);
    for (int v = 1; v <= 6; v++) begin
      tick(0, 1, v, 0);
      if (v == 4) begin
        chk("drop full", 32'(full_w[0]), 1);
        chk("drop no ovf yet", 32'(overflow_w[0]), 0);
      end
      if (v == 5) chk("drop ovf", 32'(overflow_w[0]), 1);
    end
    chk("wrap count", 32'(count_w[1]), 4);
    chk("wrap ovf", 32'(overflow_w[1]), 1);
    for (int i = 0; i < 4; i++) begin
      chk("drop drain", rd_data_w[0], 32'(i + 1));
      chk("wrap drain", rd_data_w[1], 32'(i + 3));
      tick(0, 0, 0, 1);
    end
    chk("drop empty", 32'(rd_valid_w[0]), 0);

    // Change-only capture
    tick(1, 0, 0, 0);
    exp_seq[0] = 32'h9; exp_seq[1] = 32'hA; exp_seq[2] = 32'h9;
    tick(0, 1, 9, 0);
    tick(0, 1, 9, 0);
    tick(0, 1, 9, 0);
    tick(0, 1, 'hA, 0);
    tick(0, 1, 'hA, 0);
    tick(0, 1, 9, 0);
    chk("chg count", 32'(count_w[2]), 3);
    for (int i = 0; i < 3; i++) begin
      chk("chg drain", rd_data_w[2], exp_seq[i]);
      tick(0, 0, 0, 1);
    end

    // Full with simultaneous read and write
    tick(1, 0, 0, 0);
    for (int v = 1; v <= 4; v++) tick(0, 1, v, 0);
    tick(0, 1, 8, 1);
    chk("rw count", 32'(count_w[0]), 4);
    chk("rw ovf", 32'(overflow_w[0]), 0);
    exp_seq[0] = 2; exp_seq[1] = 3; exp_seq[2] = 4; exp_seq[3] = 8;
    for (int i = 0; i < 4; i++) begin
      chk("rw drain", rd_data_w[0], exp_seq[i]);
      tick(0, 0, 0, 1);
    end

    // Reset mid-operation, then first sample always captured
    tick(1, 0, 0, 0);
    for (int v = 1; v <= 5; v++) tick(0, 1, v, 0);
    tick(0, 0, 0, 1);
    chk("mid count", 32'(count_w[0]), 3);
    chk("mid ovf", 32'(overflow_w[0]), 1);
    tick(1, 1, 77, 0);
    chk("mid rst count", 32'(count_w[0]), 0);
    chk("mid rst valid", 32'(rd_valid_w[0]), 0);
    chk("mid rst ovf", 32'(overflow_w[0]), 0);
    tick(0, 1, 4, 0);
    chk("post rst count", 32'(count_w[2]), 1);
    chk("post rst data", rd_data_w[2], 4);

    // Randomized traffic with narrow sample range so change-only sees repeats
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
           32'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_trace.md
RESULT_TRACE -- requirements
Module: result_trace

Interface
REQ-001 Parameter WIDTH, default 32: bit width of the traced result bus and of each stored entry.
REQ-002 Parameter DEPTH, default 16: number of entries; SHALL be a power of two, >= 2.
REQ-003 Parameter WRAP, default 0: 0 = drop new samples when full; 1 = overwrite oldest entry when full.
REQ-004 Parameter CHG_ONLY, default 0: 0 = capture every enabled cycle; 1 = capture only when sample differs from last captured value.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 en  input  1  capture enable; sample qualifies for capture when high.
REQ-008 sample  input  WIDTH  value to trace, typically the CPU Result bus.
REQ-009 rd_ready  input  1  consumer accepts rd_data this cycle.
REQ-010 rd_valid  output  1  at least one stored entry; rd_data is meaningful.
REQ-011 rd_data  output  WIDTH  oldest stored entry.
REQ-012 count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-013 full  output  1  count == DEPTH.
REQ-014 overflow  output  1  sticky; set when a qualifying sample was dropped or an entry overwritten.

Function
REQ-015 Capture request cap = en AND (CHG_ONLY==0 OR has_last==0 OR sample != last), where last/has_last track the most recently written entry.
REQ-016 Read transfer rd = rd_valid AND rd_ready; rd_ptr advances by 1 modulo DEPTH.
REQ-017 On cap with count < DEPTH: write sample at wr_ptr, wr_ptr advances by 1 modulo DEPTH, last <= sample, has_last <= 1.
REQ-018 Latency: sample captured at edge N SHALL appear on rd_data with rd_valid=1 in the cycle after edge N when buffer was empty (first-word fall-through, no extra cycle).
REQ-019 rd_valid SHALL equal (count != 0); rd_data SHALL equal mem[rd_ptr] while rd_valid=1.
REQ-020 count update: +1 on write without rd, -1 on rd without write, unchanged on both or neither.
REQ-021 Empty + cap + rd_ready: no read occurs (rd_valid=0); write proceeds; count becomes 1.
REQ-022 Full, WRAP=0, cap without rd: sample dropped, pointers/count/last unchanged, overflow <= 1.
REQ-023 Full, WRAP=0, cap with rd: read and write both occur, count stays DEPTH, overflow unchanged.
REQ-024 Full, WRAP=1, cap without rd: sample written at wr_ptr (overwriting oldest), wr_ptr and rd_ptr both advance, count stays DEPTH, overflow <= 1, last <= sample.
REQ-025 Full, WRAP=1, cap with rd: normal write and read, count stays DEPTH, overflow unchanged.
REQ-026 In CHG_ONLY=1 a dropped sample (REQ-022) SHALL NOT update last.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0 with no gap or duplicate entry.
REQ-028 full SHALL be combinational from count; no other output may depend combinationally on en or sample.

Reset
REQ-029 While rst=1 at an edge: wr_ptr=0, rd_ptr=0, count=0, overflow=0, has_last=0, last=0; cap and rd that cycle ignored.
REQ-030 After reset: rd_valid=0, full=0, count=0, overflow=0; rd_data undefined-but-ignored (memory contents need not reset).
REQ-031 Reset mid-operation SHALL discard all stored entries; first enabled sample afterwards is always captured (has_last=0).

Verification (DEPTH=4, WIDTH=32 unless stated)
REQ-032 rst 1 cycle, en=1, sample 5,6,7, rd_ready=0 -> count 1,2,3 on successive cycles; rd_data=5 from cycle after first capture; overflow=0.
REQ-033 WRAP=0: capture 1,2,3,4,5,6 with rd_ready=0 -> full=1 after 4th, overflow=1 after 5th; drain yields 1,2,3,4 then rd_valid=0.
REQ-034 WRAP=1: capture 1..6 with rd_ready=0 -> count=4, overflow=1; drain yields 3,4,5,6.
REQ-035 CHG_ONLY=1: sample 9,9,9,A,A,9 with en=1 -> stored 9,A,9, count=3.
REQ-036 Full (WRAP=0) holding 1..4, en=1 sample=8, rd_ready=1 for one cycle -> count stays 4, overflow=0, drain yields 2,3,4,8.
REQ-037 Buffer holding 3 entries, overflow=1, assert rst one cycle with en=1 -> count=0, rd_valid=0, overflow=0 next cycle; next enabled sample stored and visible one cycle later.
